// File: rtl/layer_para_pkg.sv
// Shared types and helpers for the double-buffered layer parameter loader.
package layer_para_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } load_state_t;

    // Per-channel set order within the parameter stream
    localparam int SET_BN_A  = 0;
    localparam int SET_BN_B  = 1;
    localparam int SET_BETA  = 2;
    localparam int SET_GAMMA = 3;
    localparam int SET_ZETA  = 4;

    // Total number of words in one complete parameter stream
    function automatic int calc_para_num(input int fm_depth, input int channel_num,
                                         input int ch_set_num);
        return fm_depth + ch_set_num * channel_num;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/layer_para_loader_bank.sv
// One parameter register bank: address decode of (region, set, element) into
// the rsign thresholds or the per-channel sets, plus the storage itself.
module para_bank
    import layer_para_pkg::*;
#(
    parameter int FM_DEPTH    = 64,
    parameter int CHANNEL_NUM = 128,
    parameter int CH_SET_NUM  = 5,
    parameter int PARA_WIDTH  = 16,
    parameter int EW          = 7,
    parameter int SW          = 3
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 we,
    input  logic                                                 rsign_sel,
    input  logic [SW-1:0]                                        set_idx,
    input  logic [EW-1:0]                                        elem_idx,
    input  logic [PARA_WIDTH-1:0]                                data,
    output logic [FM_DEPTH-1:0][PARA_WIDTH-1:0]                  rsign_para,
    output logic [CH_SET_NUM-1:0][CHANNEL_NUM-1:0][PARA_WIDTH-1:0] ch_para
);

    // Decoded write into exactly one word of the bank; cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsign_para <= '0;
            ch_para    <= '0;
        end else if (we) begin
            for (int i = 0; i < FM_DEPTH; i++) begin
                if (rsign_sel && elem_idx == EW'(i))
                    rsign_para[i] <= data;
            end
            for (int s = 0; s < CH_SET_NUM; s++) begin
                for (int c = 0; c < CHANNEL_NUM; c++) begin
                    if (!rsign_sel && set_idx == SW'(s) && elem_idx == EW'(c))
                        ch_para[s][c] <= data;
                end
            end
        end
    end

endmodule

// File: rtl/layer_para_loader.sv
// Double-buffered parameter loader: streams a full parameter set into the
// shadow bank while the active bank drives the datapath, and swaps banks
// only at a frame boundary once the shadow bank is complete.
module layer_para_loader
    import layer_para_pkg::*;
#(
    parameter int FM_DEPTH    = 64,
    parameter int CHANNEL_NUM = 128,
    parameter int CH_SET_NUM  = 5,
    parameter int PARA_WIDTH  = 16
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 mode_in,
    input  logic                                                 para_valid,
    input  logic [PARA_WIDTH-1:0]                                para_in,
    input  logic                                                 verticle_sync,
    output logic [FM_DEPTH-1:0][PARA_WIDTH-1:0]                  rsign_para,
    output logic [CH_SET_NUM-1:0][CHANNEL_NUM-1:0][PARA_WIDTH-1:0] ch_para,
    output logic                                                 load_done,
    output logic                                                 load_error,
    output logic                                                 swap_pulse,
    output logic                                                 active_bank
);

    localparam int EW_RAW = $clog2(max_int(FM_DEPTH, CHANNEL_NUM));
    localparam int EW     = (EW_RAW < 1) ? 1 : EW_RAW;
    localparam int SW     = $clog2(CH_SET_NUM + 1);

    load_state_t           state;
    logic                  rsign_phase;
    logic [EW-1:0]         elem_idx;
    logic [SW-1:0]         set_idx;
    logic                  accept;
    logic                  abort;
    logic                  rsign_end;
    logic                  set_end;
    logic                  last_word;

    logic [FM_DEPTH-1:0][PARA_WIDTH-1:0]                   rsign0, rsign1;
    logic [CH_SET_NUM-1:0][CHANNEL_NUM-1:0][PARA_WIDTH-1:0] ch0, ch1;

    // FULL never accepts; its words are overruns
    assign accept    = (state != FULL) && mode_in && para_valid;
    assign abort     = (state == LOAD) && !mode_in;
    assign rsign_end = rsign_phase && (elem_idx == EW'(FM_DEPTH - 1));
    assign set_end   = !rsign_phase && (elem_idx == EW'(CHANNEL_NUM - 1));
    assign last_word = set_end && (set_idx == SW'(CH_SET_NUM - 1));

    // Stream position: rsign region first, then set-major / channel-minor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsign_phase <= 1'b1;
            elem_idx    <= '0;
            set_idx     <= '0;
        end else if (abort || (accept && last_word)) begin
            rsign_phase <= 1'b1;
            elem_idx    <= '0;
            set_idx     <= '0;
        end else if (accept) begin
            if (rsign_end) begin
                rsign_phase <= 1'b0;
                elem_idx    <= '0;
                set_idx     <= '0;
            end else if (set_end) begin
                elem_idx    <= '0;
                set_idx     <= set_idx + SW'(1);
            end else begin
                elem_idx    <= elem_idx + EW'(1);
            end
        end
    end

    // Load sequencing, error tracking and bank swap at the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
            swap_pulse  <= 1'b0;
            active_bank <= 1'b0;
        end else begin
            swap_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        load_error <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (!mode_in) begin
                        load_error <= 1'b1;
                        state      <= IDLE;
                    end else if (accept && last_word) begin
                        load_done  <= 1'b1;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (mode_in && para_valid)
                        load_error <= 1'b1;
                    if (verticle_sync) begin
                        active_bank <= ~active_bank;
                        swap_pulse  <= 1'b1;
                        load_done   <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    para_bank #(
        .FM_DEPTH(FM_DEPTH), .CHANNEL_NUM(CHANNEL_NUM), .CH_SET_NUM(CH_SET_NUM),
        .PARA_WIDTH(PARA_WIDTH), .EW(EW), .SW(SW)
    ) u_bank0 (
        .clk(clk), .rst(rst), .we(accept && active_bank), .rsign_sel(rsign_phase),
        .set_idx(set_idx), .elem_idx(elem_idx), .data(para_in),
        .rsign_para(rsign0), .ch_para(ch0)
    );

    para_bank #(
        .FM_DEPTH(FM_DEPTH), .CHANNEL_NUM(CHANNEL_NUM), .CH_SET_NUM(CH_SET_NUM),
        .PARA_WIDTH(PARA_WIDTH), .EW(EW), .SW(SW)
    ) u_bank1 (
        .clk(clk), .rst(rst), .we(accept && !active_bank), .rsign_sel(rsign_phase),
        .set_idx(set_idx), .elem_idx(elem_idx), .data(para_in),
        .rsign_para(rsign1), .ch_para(ch1)
    );

    assign rsign_para = active_bank ? rsign1 : rsign0;
    assign ch_para    = active_bank ? ch1 : ch0;

endmodule

// File: doc/layer_para_loader.md
# layer_para_loader

Double-buffered parameter loader for the binary conv layer pipeline. It accepts the serial parameter stream (rsign thresholds, then the five per-channel BN/RPReLU sets) into a shadow bank while the active bank keeps driving rsign, bn_res and rprelu. It swaps banks only at a frame boundary (verticle_sync), so parameters can be reloaded without stalling the datapath. It replaces the single-bank loader and is generalised in depth, channel count and per-channel set count.

## Interface
- FM_DEPTH, 64, number of input feature-map channels; also the rsign parameter count
- CHANNEL_NUM, 128, number of output channels
- CH_SET_NUM, 5, number of per-channel parameter sets, in order bn_a, bn_b, beta, gamma, zeta
- PARA_WIDTH, 16, signed parameter word width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mode_in  in  1  1 = load mode; stream words accepted only while high
- para_valid  in  1  para_in carries a word this cycle
- para_in  in  PARA_WIDTH  signed parameter word
- verticle_sync  in  1  frame boundary strobe; swap point
- rsign_para  out  [FM_DEPTH] x PARA_WIDTH  active-bank rsign thresholds
- ch_para  out  [CH_SET_NUM][CHANNEL_NUM] x PARA_WIDTH  active-bank per-channel sets
- load_done  out  1  shadow bank complete and awaiting swap
- load_error  out  1  sticky error: aborted or overrun load
- swap_pulse  out  1  one-cycle strobe, the cycle after a swap takes effect
- active_bank  out  1  index of the bank currently driving the outputs

## Operation
- Stream order: rsign[0..FM_DEPTH-1], then set 0 ch 0..CHANNEL_NUM-1, then set 1, and so on to set CH_SET_NUM-1. Total N = FM_DEPTH + CH_SET_NUM*CHANNEL_NUM words.
- FSM states: IDLE, LOAD, FULL.
- IDLE: on mode_in && para_valid, write word 0 to the shadow bank, clear load_error, go to LOAD.
- LOAD: each mode_in && para_valid writes the next word. The last word (index N-1) moves to FULL.
- LOAD, mode_in falls: abort. Set load_error, go to IDLE, leave the shadow contents undefined for use and the active bank untouched.
- FULL: load_done = 1. A para_valid with mode_in set is ignored and sets load_error (overrun). On verticle_sync, toggle active_bank, go to IDLE.
- verticle_sync in IDLE or LOAD is ignored. There is no swap and the load continues.
- Counters: set index width $clog2(CH_SET_NUM+1), element index width $clog2(max(FM_DEPTH,CHANNEL_NUM)). The element index wraps to 0 and the set index increments at each set end.
- Values are stored verbatim. There is no arithmetic on parameters.

## Timing
- Reset values: both banks all zero, active_bank 0, state IDLE, load_done 0, load_error 0, swap_pulse 0. All outputs are therefore zero.
- A word accepted at edge k is stored at edge k; it is never visible on the outputs until a swap.
- Swap: verticle_sync sampled high in FULL at edge k. active_bank and all parameter outputs change after edge k, and swap_pulse is high for cycle k..k+1.
- The last word and verticle_sync in the same cycle: the word completes the load (go to FULL), and the sync is ignored; the swap waits for the next sync.
- para_valid with mode_in low is ignored in every state.
- rst mid-load or in FULL returns to reset state immediately, discarding both banks.
- A new load may start in the cycle after swap_pulse. Accepted throughput is 1 word/cycle.

## Structure
- Package layer_para_pkg holds:
  - the state enum (IDLE, LOAD, FULL);
  - set index localparams (SET_BN_A=0, SET_BN_B, SET_BETA, SET_GAMMA, SET_ZETA);
  - a function computing N from the parameters.
- Sub-module para_bank, instantiated twice, holds one register bank with a write-enable/address decoder (rsign region, then set/channel region).
- The top level holds the FSM, counters and output mux selected by active_bank.

## Test plan
All scenarios use FM_DEPTH=4, CHANNEL_NUM=4, CH_SET_NUM=5, N=24.
- Reset then idle: all outputs are 0, active_bank=0, load_done=0.
- Load words 1..24 back-to-back with mode_in=1, then verticle_sync:
  - load_done rises after word 24;
  - no output change before the sync;
  - after the sync, rsign_para={1,2,3,4}, ch_para[0]={5..8}, ch_para[4]={21..24}, active_bank=1, swap_pulse a single cycle.
- Second load of 101..124 with verticle_sync pulsed mid-load: outputs stay at the first load's values until a sync after load_done, then become 101..124, and active_bank=0.
- mode_in dropped after word 10:
  - load_error=1, state returns to IDLE;
  - a later sync causes no swap, outputs unchanged;
  - a fresh full load clears load_error and swaps correctly.
- 25th word in FULL: load_error=1; the following swap still presents words 1..24 unchanged.
- Word 24 coincident with verticle_sync: no swap that cycle; the swap occurs on the next sync. Assert rst during a later load: all outputs are 0 asynchronously.
